sccb_arbiter: RTL
=================

# sccb_arbiter

Shares the single SCCB master (`sccb_driver`) among several register-write requesters, such as the OV5640 init LUT and the runtime exposure/AWB/mirror control. The block arbitrates round-robin with an init-priority lock and issues one 24-bit write at a time. It waits for `sccb_done` or a timeout, then enforces an inter-transaction gap. It runs on the SCCB drive clock (`dri_clk`) between the requesters and `sccb_driver` inside the camera top.

## Interface
- `N_REQ`, 2: number of requesters; index 0 is the init requester.
- `GAP_CYCLES`, 8: idle clocks after each transaction completes; 0 is legal.
- `TIMEOUT_CYCLES`, 4096: clocks spent in WAIT without `sccb_done` before the write is aborted.
- `clk`  in  1  single clock (SCCB drive clock).
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  request pending; held until the matching `req_ready` pulse.
- `req_data`  in  24*N_REQ  per requester `{addr[15:0], data[7:0]}`; slot i occupies bits [24i+23:24i].
- `req_ready`  out  N_REQ  one-cycle accept pulse, one-hot.
- `req_done`  out  N_REQ  one-cycle completion pulse to the owner.
- `req_err`  out  N_REQ  one-cycle timeout pulse to the owner.
- `prio_lock`  in  1  when 1, only requester 0 is eligible (held high until `init_done`).
- `sccb_exec`  out  1  one-cycle start pulse to `sccb_driver`.
- `sccb_data`  out  24  address/data to `sccb_driver`; stable from ISSUE through the end of WAIT.
- `sccb_done`  in  1  completion pulse from `sccb_driver`.
- `busy`  out  1  state ≠ IDLE.
- `grant_id`  out  $clog2(N_REQ)  current or last owner.

## Operation
- **State machine:** IDLE → ISSUE → WAIT → GAP → IDLE.
  - If `GAP_CYCLES` = 0, WAIT goes directly to IDLE.
- **IDLE**
  - Eligible mask = `req_valid`, or `req_valid & 1` when `prio_lock` = 1.
  - If the mask is non-zero, pick the first set bit searching upward (with wrap) from `rr_ptr+1`.
  - Register the grant and latch `req_data[grant]` into `sccb_data`, then go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `sccb_exec` = 1 and `req_ready[grant]` = 1.
  - `rr_ptr` ← grant.
  - Go to WAIT.
- **WAIT**
  - Timeout counter counts from 0.
  - If `sccb_done` = 1, pulse `req_done[grant]` in the next cycle and go to GAP.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1, pulse `req_err[grant]` in the next cycle and go to GAP.
  - If `sccb_done` arrives in the timeout cycle, done wins and `req_err` stays 0.
- **GAP**
  - Count `GAP_CYCLES` cycles, then go to IDLE. Requests are not sampled during GAP.
- **Ignored inputs**
  - `sccb_done` outside WAIT is ignored.
  - Dropping `req_valid` before `req_ready` is legal and has no side effect.
  - Changes to `prio_lock` take effect at the next IDLE decision; a transaction in flight always completes.
- **Reset**
  - State = IDLE and all counters = 0.
  - All outputs are 0: `sccb_data` = 0, `grant_id` = 0.
  - `rr_ptr` = N_REQ-1, so requester 0 wins the first tie.
  - Reset mid-transaction abandons it: no `req_done`/`req_err` pulse, and the requester keeps `req_valid` and is re-served.

## Timing
- Request valid and sampled in IDLE at edge T:
  - `sccb_exec`/`req_ready` high in cycle T+1.
  - `sccb_data` valid from T+1.
- `sccb_done` sampled at edge D: `req_done` high in cycle D+1, and GAP starts at D+1.
- Minimum spacing between `sccb_exec` pulses: 2 + `GAP_CYCLES` + SCCB transfer time.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Timeout counter width is $clog2(`TIMEOUT_CYCLES`+1) and saturates; GAP counter width is $clog2(`GAP_CYCLES`+1).

## Structure
- **Package `sccb_arb_pkg`:**
  - State enum {IDLE, ISSUE, WAIT, GAP}.
  - `SCCB_WORD_W` = 24, `SCCB_ADDR_W` = 16, `SCCB_DATA_W` = 8.
- **Sub-module `rr_pick`:** combinational round-robin picker.
  - Inputs: N_REQ-wide mask and the pointer.
  - Outputs: one-hot grant, index, and any-valid flag.
  - Unit-tested separately.
- **Top-level integration:** the camera top instantiates `sccb_arbiter` between `ov5640_lut` (slot 0) and runtime control (slot 1). `cam_init_done` drives `prio_lock` inverted.

## Test plan
- **Single write:** slot 0 requests 0x3008_42; `sccb_done` 20 cycles after exec.
  - Exactly one `sccb_exec`, with `sccb_data` = 0x300842.
  - `req_ready[0]` pulses 1 cycle after the request is sampled.
  - `req_done[0]` pulses once; `busy` drops after 8 GAP cycles.
- **Round-robin:** both slots held valid continuously for 4 transactions.
  - Grants alternate 0, 1, 0, 1.
  - Exec pulses are spaced by done latency + 2 + 8.
- **Priority lock:** `prio_lock` = 1 with both slots valid.
  - Only slot 0 is served and slot 1 sees no `req_ready`.
  - After `prio_lock` falls, slot 1 is granted at the next IDLE.
- **Timeout:** `TIMEOUT_CYCLES` = 16, `sccb_done` never arrives.
  - `req_err[grant]` pulses 17 cycles after exec and `req_done` stays 0.
  - The next request is served after GAP.
- **Done/timeout collision and stray done:**
  - `sccb_done` in the final timeout cycle → `req_done` only.
  - `sccb_done` pulsed during IDLE or GAP → no output change.
- **Reset mid-WAIT:** assert `rst_n` = 0 for 1 cycle in WAIT.
  - All outputs are 0 the following cycle with no done/err pulse.
  - The still-valid slot 0 is re-issued with identical `sccb_data`.

Source files
------------

// File: rtl/sccb_arb_pkg.sv
// Shared types and widths for the SCCB write arbiter.
package sccb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam int SCCB_WORD_W = 24;
   localparam int SCCB_ADDR_W = 16;
   localparam int SCCB_DATA_W = 8;

   // Builds the {addr, data} word handed to sccb_driver.
   function automatic logic [SCCB_WORD_W-1:0] sccb_word(input logic [SCCB_ADDR_W-1:0] addr,
                                                        input logic [SCCB_DATA_W-1:0] data);
      return {addr, data};
   endfunction

endpackage

// File: rtl/sccb_arbiter_if.sv
// Requester and sccb_driver side signals of the arbiter, bundled.
// master = the arbiter itself, slave = the requesters plus sccb_driver.
interface sccb_arbiter_if #(
   parameter int N_REQ = 2
);
   import sccb_arb_pkg::*;

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]             req_valid;
   logic [SCCB_WORD_W*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]             req_ready;
   logic [N_REQ-1:0]             req_done;
   logic [N_REQ-1:0]             req_err;
   logic                         prio_lock;
   logic                         sccb_exec;
   logic [SCCB_WORD_W-1:0]       sccb_data;
   logic                         sccb_done;
   logic                         busy;
   logic [IW-1:0]                grant_id;

   modport master (
      input  req_valid, req_data, prio_lock, sccb_done,
      output req_ready, req_done, req_err, sccb_exec, sccb_data, busy, grant_id
   );

   modport slave (
      output req_valid, req_data, prio_lock, sccb_done,
      input  req_ready, req_done, req_err, sccb_exec, sccb_data, busy, grant_id
   );

endinterface

// File: rtl/sccb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit above ptr, with wrap.
module rr_pick #(
   parameter int N_REQ = 2,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] mask,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant_oh,
   output logic [IW-1:0]    grant_idx,
   output logic             any_valid
);

   int idx;

   // Walk the slots starting just after the last owner and keep the first hit.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!any_valid && mask[IW'(idx)]) begin
            any_valid            = 1'b1;
            grant_oh[IW'(idx)]   = 1'b1;
            grant_idx            = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/sccb_arbiter.sv
// Shares one sccb_driver between several register-write requesters.
// Round-robin with an init-priority lock, one write in flight, timeout and post-write gap.
module sccb_arbiter #(
   parameter int N_REQ          = 2,
   parameter int GAP_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic            clk,
   input logic            rst_n,
   sccb_arbiter_if.master bus
);
   import sccb_arb_pkg::*;

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t                 state;
   state_t                 next_state;
   logic [N_REQ-1:0]       eligible;
   logic [N_REQ-1:0]       pick_oh;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;
   logic [SCCB_WORD_W-1:0] pick_data;
   logic [IW-1:0]          rr_ptr;
   logic [IW-1:0]          grant_q;
   logic [N_REQ-1:0]       owner_oh;
   logic [SCCB_WORD_W-1:0] data_q;
   logic [TW-1:0]          to_cnt;
   logic [GW-1:0]          gap_cnt;
   logic                   exec_q;
   logic [N_REQ-1:0]       ready_q;
   logic [N_REQ-1:0]       done_q;
   logic [N_REQ-1:0]       err_q;
   logic                   busy_q;
   logic                   finish_done;
   logic                   finish_err;

   // While the init sequence holds the lock only slot 0 may compete.
   assign eligible = bus.prio_lock ? (bus.req_valid & N_REQ'(1)) : bus.req_valid;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .mask      (eligible),
      .ptr       (rr_ptr),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any_valid (pick_any)
   );

   // Select the winning slot's {addr, data} word for latching.
   always_comb begin
      pick_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) begin
            pick_data = bus.req_data[i*SCCB_WORD_W +: SCCB_WORD_W];
         end
      end
   end

   // Next-state decode; done takes precedence over a timeout in the same cycle.
   always_comb begin
      next_state  = state;
      finish_done = 1'b0;
      finish_err  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            next_state = WAIT;
         end
         WAIT: begin
            if (bus.sccb_done) begin
               finish_done = 1'b1;
            end else if (to_cnt == TO_LAST) begin
               finish_err = 1'b1;
            end
            if (finish_done || finish_err) begin
               next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Grant bookkeeping, counters and registered output pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr   <= IW'(N_REQ - 1);
         grant_q  <= '0;
         owner_oh <= '0;
         data_q   <= '0;
         to_cnt   <= '0;
         gap_cnt  <= '0;
         exec_q   <= 1'b0;
         ready_q  <= '0;
         done_q   <= '0;
         err_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         exec_q  <= 1'b0;
         ready_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
         busy_q  <= (next_state != IDLE);
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_q  <= pick_idx;
                  owner_oh <= pick_oh;
                  data_q   <= pick_data;
                  exec_q   <= 1'b1;
                  ready_q  <= pick_oh;
               end
            end
            ISSUE: begin
               rr_ptr <= grant_q;
               to_cnt <= '0;
            end
            WAIT: begin
               if (finish_done) begin
                  done_q <= owner_oh;
               end
               if (finish_err) begin
                  err_q <= owner_oh;
               end
               if (to_cnt != '1) begin
                  to_cnt <= to_cnt + 1'b1;
               end
               gap_cnt <= '0;
            end
            GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.sccb_exec = exec_q;
   assign bus.sccb_data = data_q;
   assign bus.req_ready = ready_q;
   assign bus.req_done  = done_q;
   assign bus.req_err   = err_q;
   assign bus.busy      = busy_q;
   assign bus.grant_id  = grant_q;

endmodule
